// File: rtl/bubble_spawn_if.sv
// Descriptor handshake between the bubble spawn scheduler and the renderer.
interface bubble_spawn_if #(
  parameter int CIRNUM = 32
);
  localparam int SLOT_W = $clog2(CIRNUM);

  logic              spawn_valid;
  logic              spawn_ready;
  logic [10:0]       spawn_x;
  logic [10:0]       spawn_y;
  logic [10:0]       spawn_rad;
  logic [SLOT_W-1:0] spawn_slot;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_rad, spawn_slot,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_rad, spawn_slot,
    output spawn_ready
  );
endinterface

// File: rtl/bubble_spawn_scheduler.sv
// Queues beat/auto spawn requests, paces them by VGA frames and offers one
// computed circle descriptor at a time to the renderer.
module bubble_spawn_scheduler #(
  parameter int CIRNUM             = 32,
  parameter int FIFO_DEPTH         = 4,
  parameter int MIN_GAP_FRAMES     = 4,
  parameter int AUTO_PERIOD_FRAMES = 30,
  parameter int BASE_RAD           = 45
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_frame_start,
  input  logic           i_beat,
  input  logic [4:0]     i_level,
  input  logic [21:0]    i_rand,
  bubble_spawn_if.master spawn,
  output logic [7:0]     o_drop_cnt,
  output logic           o_busy
);
  localparam int SLOT_W = $clog2(CIRNUM);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GAP_W  = $clog2(MIN_GAP_FRAMES + 2);
  localparam int AUTO_W = $clog2(AUTO_PERIOD_FRAMES + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_OFFER} state_t;

  state_t            state_q, state_d;
  logic [4:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [4:0]        level_q;
  logic [GAP_W-1:0]  gap_q;
  logic [AUTO_W-1:0] auto_q;
  logic [SLOT_W-1:0] slot_q;
  logic [7:0]        drop_q;
  logic              busy_q, valid_q;
  logic [10:0]       x_q, y_q, rad_q;

  logic       pop, handshake, room, auto_expire, push, drop;
  logic [4:0] push_data;
  logic [9:0] rx;
  logic [8:0] ry;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0 && gap_q == '0) begin
          pop     = 1'b1;
          state_d = ST_GEN;
        end
      end
      ST_GEN:   state_d = ST_OFFER;
      ST_OFFER: begin
        if (spawn.spawn_ready) begin
          handshake = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // A full queue still takes a request when its head leaves on the same edge;
  // a beat always wins over a coincident auto expiry.
  always_comb begin
    room        = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
    auto_expire = i_frame_start && (auto_q == AUTO_W'(AUTO_PERIOD_FRAMES - 1));
    push        = room && (i_beat || auto_expire);
    push_data   = i_beat ? i_level : 5'd0;
    drop        = i_beat && !room;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    rx          = i_rand[9:0];
    ry          = i_rand[18:10];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      level_q  <= '0;
      gap_q    <= '0;
      auto_q   <= '0;
      slot_q   <= '0;
      drop_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      rad_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= (state_d != ST_IDLE) || (count_d != '0);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        level_q  <= fifo_mem[rd_ptr_q];
      end
      if (push || auto_expire)  auto_q <= '0;
      else if (i_frame_start)   auto_q <= auto_q + AUTO_W'(1);
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (handshake)                          gap_q <= GAP_W'(MIN_GAP_FRAMES);
      else if (i_frame_start && gap_q != '0)  gap_q <= gap_q - GAP_W'(1);
      if (state_q == ST_GEN) begin
        x_q     <= (rx >= 10'd640) ? {1'b0, rx - 10'd512} : {1'b0, rx};
        y_q     <= (ry >= 9'd480)  ? {2'b0, ry - 9'd256}  : {2'b0, ry};
        rad_q   <= 11'(BASE_RAD) + {4'd0, level_q, 2'd0} + {8'd0, i_rand[21:19]};
        valid_q <= 1'b1;
      end
      if (handshake) begin
        valid_q <= 1'b0;
        slot_q  <= (slot_q == SLOT_W'(CIRNUM - 1)) ? '0 : slot_q + SLOT_W'(1);
      end
    end
  end

  // NOTE: queue storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_x     = x_q;
  assign spawn.spawn_y     = y_q;
  assign spawn.spawn_rad   = rad_q;
  assign spawn.spawn_slot  = slot_q;
  assign o_drop_cnt        = drop_q;
  assign o_busy            = busy_q;
endmodule

// File: tb/tb_bubble_spawn_scheduler.sv
// Directed scenarios plus random traffic, checked every cycle against a
// queue-based behavioural model of the spawn scheduler.
module tb_bubble_spawn_scheduler;
  localparam int CIRNUM      = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int MIN_GAP     = 4;
  localparam int AUTO_PERIOD = 30;
  localparam int BASE_RAD    = 45;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_beat = 1'b0;
  logic [4:0]  i_level = '0;
  logic [21:0] i_rand = '0;
  logic [7:0]  o_drop_cnt;
  logic        o_busy;

  bubble_spawn_if #(.CIRNUM(CIRNUM)) spawn_if ();

  bubble_spawn_scheduler #(
    .CIRNUM(CIRNUM), .FIFO_DEPTH(FIFO_DEPTH), .MIN_GAP_FRAMES(MIN_GAP),
    .AUTO_PERIOD_FRAMES(AUTO_PERIOD), .BASE_RAD(BASE_RAD)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_beat(i_beat),
    .i_level(i_level), .i_rand(i_rand), .spawn(spawn_if),
    .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending levels and a phase per descriptor.
  int m_q[$];
  int m_phase;   // 0 waiting, 1 descriptor being built, 2 on offer
  int m_level, m_gap, m_timer, m_slot, m_drop, m_x, m_y, m_rad;
  bit m_valid, m_busy;

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_level = 0; m_gap = 0; m_timer = 0; m_slot = 0; m_drop = 0;
    m_x = 0; m_y = 0; m_rad = 0; m_valid = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit pop, hs, room;
    int r;
    pop  = (m_phase == 0) && (m_q.size() > 0) && (m_gap == 0);
    hs   = (m_phase == 2) && spawn_if.spawn_ready;
    room = (m_q.size() < FIFO_DEPTH) || pop;
    if (pop) m_level = m_q.pop_front();
    if (i_beat && room) begin
      m_q.push_back(int'(i_level));
      m_timer = 0;
    end else begin
      if (i_beat) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (i_frame_start) begin
        if (m_timer == AUTO_PERIOD - 1) begin
          m_timer = 0;
          if (room) m_q.push_back(0);
        end else begin
          m_timer++;
        end
      end
    end
    if (hs) m_gap = MIN_GAP;
    else if (i_frame_start && m_gap > 0) m_gap--;
    case (m_phase)
      0: if (pop) m_phase = 1;
      1: begin
        r     = int'(i_rand[9:0]);
        m_x   = (r >= 640) ? r - 512 : r;
        r     = int'(i_rand[18:10]);
        m_y   = (r >= 480) ? r - 256 : r;
        m_rad = BASE_RAD + 4 * m_level + int'(i_rand[21:19]);
        m_valid = 1;
        m_phase = 2;
      end
      default: if (hs) begin
        m_valid = 0;
        m_slot  = (m_slot + 1) % CIRNUM;
        m_phase = 0;
      end
    endcase
    m_busy = (m_phase != 0) || (m_q.size() != 0);
  endtask

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) model_reset();
    else       model_step();
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("valid", spawn_if.spawn_valid, m_valid);
      check("x",     spawn_if.spawn_x,     m_x);
      check("y",     spawn_if.spawn_y,     m_y);
      check("rad",   spawn_if.spawn_rad,   m_rad);
      check("slot",  spawn_if.spawn_slot,  m_slot);
      check("drop",  o_drop_cnt,           m_drop);
      check("busy",  o_busy,               m_busy);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic frame_pulse();
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
  endtask

  task automatic spaced_frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_pulse();
      step();
      step();
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!spawn_if.spawn_valid && n < budget) begin
      step();
      n++;
    end
    check(tag, spawn_if.spawn_valid, 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_beat = 1'b0; i_frame_start = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, spawn_if.spawn_valid, 0);
    check({tag, "_x"},     spawn_if.spawn_x,     0);
    check({tag, "_y"},     spawn_if.spawn_y,     0);
    check({tag, "_rad"},   spawn_if.spawn_rad,   0);
    check({tag, "_slot"},  spawn_if.spawn_slot,  0);
    check({tag, "_drop"},  o_drop_cnt,           0);
    check({tag, "_busy"},  o_busy,               0);
  endtask

  initial begin
    int hs_at[$];
    int pulses;
    logic [4:0] prev_slot;

    spawn_if.spawn_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    i_rst = 1'b0;

    // Single beat with ready tied high: E+2 latency, fixed descriptor.
    spawn_if.spawn_ready = 1'b1;
    i_rand  = {3'd5, 9'd300, 10'd700};
    i_beat  = 1'b1; i_level = 5'd10;
    step();
    i_beat = 1'b0;
    step();
    check("lat_e1_valid", spawn_if.spawn_valid, 0);
    step();
    check("single_valid", spawn_if.spawn_valid, 1);
    check("single_x",     spawn_if.spawn_x,     188);
    check("single_y",     spawn_if.spawn_y,     300);
    check("single_rad",   spawn_if.spawn_rad,   90);
    check("single_slot",  spawn_if.spawn_slot,  0);
    step();
    check("single_hs_valid", spawn_if.spawn_valid, 0);
    check("single_hs_slot",  spawn_if.spawn_slot,  1);

    // Backpressure: descriptor held for 50 cycles while i_rand moves.
    spawn_if.spawn_ready = 1'b0;
    repeat (MIN_GAP) frame_pulse();
    i_rand = {3'd1, 9'd479, 10'd640};
    i_beat = 1'b1; i_level = 5'd7;
    step();
    i_beat = 1'b0;
    wait_valid("bp_valid_rise", 10);
    for (int k = 0; k < 50; k++) begin
      i_rand = 22'($urandom);
      step();
      check("bp_valid", spawn_if.spawn_valid, 1);
      check("bp_x",     spawn_if.spawn_x,     128);
      check("bp_y",     spawn_if.spawn_y,     479);
      check("bp_rad",   spawn_if.spawn_rad,   74);
      check("bp_slot",  spawn_if.spawn_slot,  1);
    end
    spawn_if.spawn_ready = 1'b1;
    step();
    check("bp_hs_valid", spawn_if.spawn_valid, 0);
    repeat (3) step();
    check("bp_one_hs_slot", spawn_if.spawn_slot, 2);

    // Drop counter saturation, left on offer for the reset test below.
    spawn_if.spawn_ready = 1'b0;
    repeat (MIN_GAP) frame_pulse();
    i_rand = {3'd7, 9'd480, 10'd1023};
    i_beat = 1'b1; i_level = 5'd31;
    repeat (310) step();
    i_beat = 1'b0;
    check("sat_drop",  o_drop_cnt,          255);
    check("sat_valid", spawn_if.spawn_valid, 1);
    check("max_x",     spawn_if.spawn_x,     511);
    check("max_y",     spawn_if.spawn_y,     224);
    check("max_rad",   spawn_if.spawn_rad,   176);

    // Asynchronous reset in the middle of OFFER.
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_all_zero("async_rst");
    step();
    i_rst = 1'b0;

    // Quiet audio: first auto spawn after exactly 30 frame pulses.
    spawn_if.spawn_ready = 1'b1;
    i_rand = {3'd3, 9'd10, 10'd20};
    spaced_frames(AUTO_PERIOD - 1);
    check("auto_pre_valid", spawn_if.spawn_valid, 0);
    check("auto_pre_busy",  o_busy,               0);
    frame_pulse();
    check("auto_push_busy", o_busy, 1);
    step();
    step();
    check("auto_valid", spawn_if.spawn_valid, 1);
    check("auto_rad",   spawn_if.spawn_rad,   48);
    step();

    // Beat collides with the 30th quiet frame pulse.
    do_reset();
    spawn_if.spawn_ready = 1'b1;
    i_rand = {3'd2, 9'd100, 10'd50};
    spaced_frames(AUTO_PERIOD - 1);
    i_frame_start = 1'b1; i_beat = 1'b1; i_level = 5'd17;
    step();
    i_frame_start = 1'b0; i_beat = 1'b0;
    step();
    step();
    check("collide_valid", spawn_if.spawn_valid, 1);
    check("collide_rad",   spawn_if.spawn_rad,   115);
    step();
    repeat (3) step();
    check("collide_one_entry", o_busy, 0);
    spaced_frames(AUTO_PERIOD - 1);
    check("collide_restart_quiet", spawn_if.spawn_valid, 0);
    frame_pulse();
    step();
    step();
    check("collide_restart_valid", spawn_if.spawn_valid, 1);
    check("collide_restart_rad",   spawn_if.spawn_rad,   47);
    step();

    // Burst of 6 beats with ready low, then paced by frame pulses.
    do_reset();
    spawn_if.spawn_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      i_beat = 1'b1; i_level = 5'(k);
      step();
    end
    i_beat = 1'b0;
    check("burst_drop",  o_drop_cnt,          1);
    check("burst_valid", spawn_if.spawn_valid, 1);
    spawn_if.spawn_ready = 1'b1;
    pulses    = 0;
    prev_slot = spawn_if.spawn_slot;
    for (int c = 0; c < 3000 && hs_at.size() < 5; c++) begin
      i_frame_start = (c % 100 == 99);
      i_rand = 22'($urandom);
      step();
      if (i_frame_start) pulses++;
      i_frame_start = 1'b0;
      if (spawn_if.spawn_slot != prev_slot) hs_at.push_back(pulses);
      prev_slot = spawn_if.spawn_slot;
    end
    check("burst_spawns", hs_at.size(), 5);
    for (int k = 1; k < hs_at.size(); k++) check("burst_spacing", hs_at[k] - hs_at[k-1], MIN_GAP);

    // Slot wrap over 33 handshakes.
    do_reset();
    spawn_if.spawn_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      i_rand = 22'($urandom);
      i_beat = 1'b1; i_level = 5'($urandom);
      step();
      i_beat = 1'b0;
      wait_valid("wrap_valid", 10);
      check("wrap_slot", spawn_if.spawn_slot, k % CIRNUM);
      step();
      repeat (MIN_GAP) frame_pulse();
    end
    check("wrap_final_slot", spawn_if.spawn_slot, 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      i_beat               = ($urandom_range(0, 5) == 0);
      i_frame_start        = ($urandom_range(0, 7) == 0);
      spawn_if.spawn_ready = ($urandom_range(0, 2) != 0);
      i_level              = 5'($urandom);
      i_rand               = 22'($urandom);
      step();
    end
    i_beat = 1'b0; i_frame_start = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
